// File: rtl/windowed_rep_pkg.sv
// Shared types and default sizing for the windowed repetition counter.
// Imported by windowed_rep_counter and rep_rmw_ram.
package windowed_rep_pkg;

  localparam int DEF_FIELD_SIZE = 16;
  localparam int DEF_REP_BITS   = 2;
  localparam int DEF_EPOCH_BITS = 3;
  localparam int DEF_WND_BITS   = 5;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

endpackage

// File: rtl/rep_rmw_ram.sv
// Per-key counter RAM with read-modify-write pipeline and forwarding.
// Ports: init write, S0 sample in, rep threshold; S2 valid/last/rep out.
module rep_rmw_ram
  import windowed_rep_pkg::*;
#(
  parameter int FIELD_SIZE = DEF_FIELD_SIZE,
  parameter int REP_BITS   = DEF_REP_BITS,
  parameter int EPOCH_BITS = DEF_EPOCH_BITS
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_init_we,
  input  logic [FIELD_SIZE-1:0] i_init_addr,
  input  logic [REP_BITS-1:0]   i_rep_thresh,
  input  logic                  i_s0_vld,
  input  logic [FIELD_SIZE-1:0] i_s0_key,
  input  logic [EPOCH_BITS-1:0] i_s0_epoch,
  input  logic                  i_s0_last,
  output logic                  o_s2_vld,
  output logic                  o_s2_last,
  output logic                  o_s2_rep
);

  typedef struct packed {
    logic [EPOCH_BITS-1:0] tag;
    logic [REP_BITS-1:0]   cnt;
  } rep_word_t;

  typedef struct packed {
    logic                  vld;
    logic [FIELD_SIZE-1:0] key;
    logic [EPOCH_BITS-1:0] epoch;
    logic                  last;
  } pipe_stage_t;

  localparam int DEPTH = 1 << FIELD_SIZE;
  localparam logic [REP_BITS-1:0] CNT_MAX = '1;

  rep_word_t   r_mem [DEPTH];
  rep_word_t   r_rd;
  rep_word_t   r_fwd_word;
  logic        r_fwd;
  pipe_stage_t r_s2;

  pipe_stage_t           w_s0;
  rep_word_t             w_word;
  rep_word_t             w_wr_word;
  rep_word_t             w_wdata;
  logic [REP_BITS-1:0]   w_eff;
  logic [FIELD_SIZE-1:0] w_waddr;
  logic                  w_we;

  always_comb begin
    w_s0       = '0;
    w_s0.vld   = i_s0_vld;
    w_s0.key   = i_s0_key;
    w_s0.epoch = i_s0_epoch;
    w_s0.last  = i_s0_last;
  end

  // Forwarded word first, then tag check: a window boundary
  // between two same-key samples still reads as a clean count.
  always_comb begin
    w_word = r_fwd ? r_fwd_word : r_rd;
    w_eff  = (w_word.tag == r_s2.epoch) ? w_word.cnt : '0;
    w_wr_word     = '0;
    w_wr_word.tag = r_s2.epoch;
    w_wr_word.cnt = (w_eff == CNT_MAX) ? CNT_MAX : w_eff + 1'b1;
  end

  always_comb begin
    w_we    = i_init_we | r_s2.vld;
    w_waddr = i_init_we ? i_init_addr : r_s2.key;
    w_wdata = i_init_we ? '0 : w_wr_word;
  end

  assign o_s2_vld  = r_s2.vld;
  assign o_s2_last = r_s2.last;
  assign o_s2_rep  = r_s2.vld & (w_eff >= i_rep_thresh);

  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    r_rd       <= r_mem[w_s0.key];
    r_fwd_word <= w_wr_word;
  end

  // Same-key sample right behind: its RAM read misses this write.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s2  <= '0;
      r_fwd <= 1'b0;
    end else begin
      r_s2  <= w_s0;
      r_fwd <= r_s2.vld & w_s0.vld & (r_s2.key == w_s0.key);
    end
  end

endmodule

// File: rtl/windowed_rep_counter.sv
// Windowed repetition detector: epoch-tagged per-key counters, rate per window.
// Ports: cfg window/thresholds, valid/field in; ready, rep_rate, rate_valid, found out.
module windowed_rep_counter
  import windowed_rep_pkg::*;
#(
  parameter int FIELD_SIZE = DEF_FIELD_SIZE,
  parameter int REP_BITS   = DEF_REP_BITS,
  parameter int EPOCH_BITS = DEF_EPOCH_BITS,
  parameter int WND_BITS   = DEF_WND_BITS,
  parameter int RATE_BITS  = WND_BITS + 1
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic [WND_BITS-1:0]   cfg_window_len,
  input  logic [REP_BITS-1:0]   cfg_rep_thresh,
  input  logic [RATE_BITS-1:0]  cfg_found_thresh,
  input  logic                  valid,
  input  logic [FIELD_SIZE-1:0] field,
  output logic                  ready,
  output logic [RATE_BITS-1:0]  rep_rate,
  output logic                  rate_valid,
  output logic                  found
);

  localparam logic [FIELD_SIZE-1:0] LAST_ADDR = '1;
  localparam logic [EPOCH_BITS-1:0] EPOCH_MAX = '1;
  localparam logic [EPOCH_BITS-1:0] EPOCH_1   = EPOCH_BITS'(1);

  state_e                r_state;
  logic [FIELD_SIZE-1:0] r_init_addr;
  logic [EPOCH_BITS-1:0] r_epoch;
  logic [WND_BITS-1:0]   r_wcnt;
  logic [WND_BITS-1:0]   r_wlen;
  logic                  r_s0_vld;
  logic [FIELD_SIZE-1:0] r_s0_key;
  logic [EPOCH_BITS-1:0] r_s0_epoch;
  logic                  r_s0_last;
  logic [RATE_BITS-1:0]  r_acc;

  logic                  w_accept;
  logic                  w_last;
  logic [WND_BITS-1:0]   w_len;
  logic                  w_s2_vld;
  logic                  w_s2_last;
  logic                  w_s2_rep;
  logic [RATE_BITS-1:0]  w_acc_nxt;

  assign w_accept = valid & ready;
  // Length is latched at window start; later cfg edits wait.
  assign w_len     = (r_wcnt == '0) ? cfg_window_len : r_wlen;
  assign w_last    = (r_wcnt == w_len);
  assign w_acc_nxt = r_acc + RATE_BITS'(w_s2_rep);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_init_addr <= '0;
      ready       <= 1'b0;
      r_epoch     <= '0;
    end else begin
      unique case (r_state)
        ST_INIT: begin
          r_init_addr <= r_init_addr + 1'b1;
          if (r_init_addr == LAST_ADDR) begin
            r_state <= ST_RUN;
            ready   <= 1'b1;
            r_epoch <= EPOCH_1;
          end
        end
        ST_RUN: begin
          // Epoch 0 is reserved for the cleared RAM image.
          if (w_accept && w_last)
            r_epoch <= (r_epoch == EPOCH_MAX) ? EPOCH_1
                                              : r_epoch + 1'b1;
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_wcnt     <= '0;
      r_wlen     <= '0;
      r_s0_vld   <= 1'b0;
      r_s0_key   <= '0;
      r_s0_epoch <= '0;
      r_s0_last  <= 1'b0;
    end else begin
      r_s0_vld <= w_accept;
      if (w_accept) begin
        r_s0_key   <= field;
        r_s0_epoch <= r_epoch;
        r_s0_last  <= w_last;
        r_wlen     <= w_len;
        r_wcnt     <= w_last ? '0 : r_wcnt + 1'b1;
      end
    end
  end

  rep_rmw_ram #(
    .FIELD_SIZE (FIELD_SIZE),
    .REP_BITS   (REP_BITS),
    .EPOCH_BITS (EPOCH_BITS)
  ) u_ram (
    .i_clk        (sys_clk),
    .i_reset      (reset),
    .i_init_we    (r_state == ST_INIT),
    .i_init_addr  (r_init_addr),
    .i_rep_thresh (cfg_rep_thresh),
    .i_s0_vld     (r_s0_vld),
    .i_s0_key     (r_s0_key),
    .i_s0_epoch   (r_s0_epoch),
    .i_s0_last    (r_s0_last),
    .o_s2_vld     (w_s2_vld),
    .o_s2_last    (w_s2_last),
    .o_s2_rep     (w_s2_rep)
  );

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_acc      <= '0;
      rep_rate   <= '0;
      rate_valid <= 1'b0;
      found      <= 1'b0;
    end else begin
      rate_valid <= 1'b0;
      if (w_s2_vld) begin
        if (w_s2_last) begin
          r_acc      <= '0;
          rep_rate   <= w_acc_nxt;
          rate_valid <= 1'b1;
          found      <= (w_acc_nxt >= cfg_found_thresh);
        end else begin
          r_acc <= w_acc_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_windowed_rep_counter.sv
// Randomized + directed bench for windowed_rep_counter.
// Window-level reference model; small config (16 keys, 3 live epochs).
module tb_windowed_rep_counter;

  localparam int FS   = 4;
  localparam int RB   = 2;
  localparam int EB   = 2;
  localparam int WB   = 3;
  localparam int QB   = WB + 1;
  localparam int NKEY = 1 << FS;
  localparam int CMAX = (1 << RB) - 1;
  localparam int NEP  = (1 << EB) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [WB-1:0] cfg_len = '0;
  logic [RB-1:0] cfg_rep = '0;
  logic [QB-1:0] cfg_fnd = '0;
  logic          vld = 1'b0;
  logic [FS-1:0] key_in = '0;
  logic          ready;
  logic [QB-1:0] rep_rate;
  logic          rate_valid;
  logic          found;

  always #5 clk = ~clk;

  windowed_rep_counter #(
    .FIELD_SIZE (FS),
    .REP_BITS   (RB),
    .EPOCH_BITS (EB),
    .WND_BITS   (WB),
    .RATE_BITS  (QB)
  ) dut (
    .sys_clk          (clk),
    .reset            (rst),
    .cfg_window_len   (cfg_len),
    .cfg_rep_thresh   (cfg_rep),
    .cfg_found_thresh (cfg_fnd),
    .valid            (vld),
    .field            (key_in),
    .ready            (ready),
    .rep_rate         (rep_rate),
    .rate_valid       (rate_valid),
    .found            (found)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Model: per key, count and the window index it was last written in.
  // Stored count is live when the window distance is a multiple of NEP.
  int m_cnt [NKEY];
  int m_lw  [NKEY];
  int m_pos, m_len, m_win, m_acc, m_init;
  int q_due [$];
  int q_rate [$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NKEY; i++) begin
      m_cnt[i] = 0;
      m_lw[i]  = -1;
    end
    m_pos  = 0;
    m_len  = 0;
    m_win  = 0;
    m_acc  = 0;
    m_init = NKEY;
    q_due.delete();
    q_rate.delete();
  endtask

  task automatic model_sample(input int k);
    int eff;
    if (m_pos == 0) m_len = int'(cfg_len);
    eff = 0;
    if (m_lw[k] >= 0 && ((m_win - m_lw[k]) % NEP) == 0)
      eff = m_cnt[k];
    if (eff >= int'(cfg_rep)) m_acc++;
    m_cnt[k] = (eff + 1 > CMAX) ? CMAX : eff + 1;
    m_lw[k]  = m_win;
    if (m_pos == m_len) begin
      q_due.push_back(cyc + 2);
      q_rate.push_back(m_acc);
      m_acc = 0;
      m_pos = 0;
      m_win++;
    end else begin
      m_pos++;
    end
  endtask

  task automatic step(input bit v, input int k);
    bit acc;
    vld    = v;
    key_in = FS'(k);
    acc    = v && (m_init == 0) && !rst;
    @(posedge clk);
    cyc++;
    #1;
    if (rst) begin
      model_reset();
    end else begin
      if (m_init > 0) m_init--;
      if (acc) model_sample(k);
    end
    check("ready", ready, m_init == 0);
    if (q_due.size() > 0 && q_due[0] == cyc) begin
      check("rate_valid", rate_valid, 1);
      check("rep_rate", rep_rate, q_rate[0]);
      check("found", found, q_rate[0] >= int'(cfg_fnd));
      void'(q_due.pop_front());
      void'(q_rate.pop_front());
    end else begin
      check("rate_valid_idle", rate_valid, 0);
    end
  endtask

  task automatic do_reset(input bit v);
    rst = 1'b1;
    step(v, 0);
    rst = 1'b0;
    check("rst_rep_rate", rep_rate, 0);
    check("rst_found", found, 0);
  endtask

  task automatic drain();
    repeat (4) step(0, 0);
  endtask

  int t2_keys [8] = '{3, 3, 3, 5, 6, 7, 5, 9};
  int t3_keys [8] = '{3, 0, 1, 4, 8, 10, 11, 12};
  int t6_keys [8] = '{5, 5, 6, 7, 8, 9, 10, 11};

  initial begin
    model_reset();
    cfg_len = WB'(7);
    cfg_rep = RB'(1);
    cfg_fnd = QB'(0);

    // init sweep with valid held high
    do_reset(1);
    for (int i = 0; i < NKEY; i++) step(1, i);

    // back-to-back repeats through the forwarding path
    foreach (t2_keys[i]) step(1, t2_keys[i]);
    drain();
    check("t2_rate", rep_rate, 3);

    // next window: stale counts from the previous epoch ignored
    foreach (t3_keys[i]) step(1, t3_keys[i]);
    drain();
    check("t3_rate", rep_rate, 0);

    // saturating counter, found threshold both ways
    cfg_rep = RB'(3);
    cfg_fnd = QB'(5);
    repeat (8) step(1, 2);
    drain();
    check("t4_rate", rep_rate, 5);
    check("t4_found_hi", found, 1);
    cfg_fnd = QB'(6);
    repeat (8) step(1, 2);
    drain();
    check("t4_rate2", rep_rate, 5);
    check("t4_found_lo", found, 0);

    // gaps plus a mid-window length change
    cfg_rep = RB'(1);
    cfg_fnd = QB'(2);
    cfg_len = WB'(3);
    step(1, 13);
    step(0, 0);
    step(1, 13);
    step(0, 0);
    step(0, 0);
    cfg_len = WB'(5);
    step(1, 13);
    step(1, 7);
    drain();
    check("t5_rate_old_len", rep_rate, 2);
    repeat (6) step(1, 4);
    drain();
    check("t5_rate_new_len", rep_rate, 5);

    // reset mid-window
    cfg_len = WB'(7);
    repeat (3) step(1, 5);
    do_reset(1);
    check("t6_ready_low", ready, 0);
    for (int i = 0; i < NKEY; i++) step(0, 0);
    foreach (t6_keys[i]) step(1, t6_keys[i]);
    drain();
    check("t6_rate", rep_rate, 1);

    // randomized traffic; rep threshold only moves when idle
    for (int blk = 0; blk < 20; blk++) begin
      drain();
      cfg_rep = RB'($urandom_range(0, CMAX));
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 7) == 0)
          cfg_len = WB'($urandom_range(0, (1 << WB) - 1));
        if ($urandom_range(0, 5) == 0)
          cfg_fnd = QB'($urandom_range(0, 1 << WB));
        if (blk == 11 && i == 30) begin
          do_reset($urandom_range(0, 1) == 1);
        end else begin
          step($urandom_range(0, 3) != 0,
               $urandom_range(0, NKEY - 1));
        end
      end
    end
    drain();
    check("end_queue_empty", q_due.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
